// File: rtl/z16_mmio_pkg.sv
// Shared definitions for the Z16 memory-mapped I/O window.
// Holds the register addresses, the BTN status bit positions, reset values
// and the address decoder, so the core and any future MMIO block agree on
// one map.
package z16_mmio_pkg;

  localparam logic [15:0] ADDR_TICK = 16'h0078;
  localparam logic [15:0] ADDR_LED  = 16'h007A;
  localparam logic [15:0] ADDR_BTN  = 16'h007C;

  localparam int BTN_LEVEL_BIT = 0;
  localparam int BTN_PRESS_BIT = 1;

  localparam int LED_W = 6;

  localparam logic [LED_W-1:0] LED_RST  = '0;
  localparam logic [15:0]      TICK_RST = 16'h0000;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_TICK,
    REG_LED,
    REG_BTN
  } reg_sel_e;

  // Exact 16-bit match only; neighbouring byte addresses are unmapped.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    case (addr)
      ADDR_TICK: sel = REG_TICK;
      ADDR_LED:  sel = REG_LED;
      ADDR_BTN:  sel = REG_BTN;
      default:   sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/z16_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stable-sample
// counter. The debounced level flips only after DEB_CYCLES consecutive
// synchronised samples that differ from it.
// Ports:
//   i_clk     core clock
//   i_rst_n   synchronous active-low reset
//   i_button  raw asynchronous button, active-high
//   o_level   debounced level (registered)
//   o_rise    high in the cycle whose closing edge raises o_level
module z16_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] count_q;
  logic             differs;
  logic             toggle;

  assign differs = (sync_q2 != level_q);
  assign toggle  = differs && (count_q == CNT_MAX);

  // Combinational so the press flag in the parent sets on the same edge the
  // level rises; derived from registers only.
  assign o_rise  = toggle && !level_q;
  assign o_level = level_q;

  // NOTE: reset is synchronous (sampled on the clock edge), so it lives
  // inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make the synchroniser a true two-stage
      // shift; blocking here would collapse it into one flop.
      sync_q1 <= i_button;
      sync_q2 <= sync_q1;
      if (toggle) begin
        level_q <= ~level_q;
        count_q <= '0;
      end else if (differs) begin
        count_q <= count_q + 1'b1;
      end else begin
        count_q <= '0;
      end
    end
  end

endmodule

// File: rtl/z16_mmio_periph.sv
// MMIO responder for the Z16 data bus: LED register, debounced button
// status with sticky press flag, and a free-running tick counter.
// Reads are combinational from i_addr; stores take effect on the next edge.
// Ports:
//   i_clk, i_rst_n  clock and synchronous active-low reset
//   i_addr          data address from the core
//   i_wen, i_wdata  store strobe and data
//   o_rdata, o_hit  read data and "address is mapped" (combinational)
//   i_button        raw push-button input
//   o_led           registered LED drive
module z16_mmio_periph
  import z16_mmio_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int TICK_DIV   = 27000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [15:0]      i_addr,
  input  logic             i_wen,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  output logic             o_hit,
  input  logic             i_button,
  output logic [LED_W-1:0] o_led
);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("z16_mmio_periph: DEB_CYCLES must be >= 2");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("z16_mmio_periph: TICK_DIV must be >= 2");
  end

  localparam int PRE_W = $clog2(TICK_DIV) + 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  reg_sel_e          sel;
  logic [PRE_W-1:0]  prescale_q;
  logic [15:0]       tick_q;
  logic [LED_W-1:0]  led_q;
  logic              press_q;
  logic              btn_level;
  logic              btn_rise;
  logic              tick_wrap;
  logic              wr_tick;
  logic              wr_led;
  logic              clr_press;

  z16_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_button (i_button),
    .o_level  (btn_level),
    .o_rise   (btn_rise)
  );

  assign sel       = decode_addr(i_addr);
  assign tick_wrap = (prescale_q == PRE_MAX);
  assign wr_tick   = i_wen && (sel == REG_TICK);
  assign wr_led    = i_wen && (sel == REG_LED);
  assign clr_press = i_wen && (sel == REG_BTN) && i_wdata[BTN_PRESS_BIT];

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    o_hit   = 1'b0;
    o_rdata = 16'h0000;
    case (sel)
      REG_TICK: begin
        o_hit   = 1'b1;
        o_rdata = tick_q;
      end
      REG_LED: begin
        o_hit   = 1'b1;
        o_rdata = {{(16 - LED_W){1'b0}}, led_q};
      end
      REG_BTN: begin
        o_hit                  = 1'b1;
        o_rdata[BTN_LEVEL_BIT] = btn_level;
        o_rdata[BTN_PRESS_BIT] = press_q;
      end
      default: begin
        o_hit   = 1'b0;
        o_rdata = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prescale_q <= '0;
      tick_q     <= TICK_RST;
      led_q      <= LED_RST;
      press_q    <= 1'b0;
    end else begin
      // A store to TICK does not disturb the prescaler phase.
      prescale_q <= tick_wrap ? '0 : prescale_q + 1'b1;

      // Store beats a coincident increment.
      if (wr_tick) begin
        tick_q <= i_wdata;
      end else if (tick_wrap) begin
        tick_q <= tick_q + 16'd1;
      end

      if (wr_led) begin
        led_q <= i_wdata[LED_W-1:0];
      end

      // A new press beats a coincident clear so no press is ever lost.
      if (btn_rise) begin
        press_q <= 1'b1;
      end else if (clr_press) begin
        press_q <= 1'b0;
      end
    end
  end

  assign o_led = led_q;

endmodule

// File: tb/tb_z16_mmio_periph.sv
// Directed bench for z16_mmio_periph with DEB_CYCLES=4, TICK_DIV=3.
module tb_z16_mmio_periph;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        wen;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        hit;
  logic        button;
  logic [5:0]  led;

  int checks;
  int errors;

  z16_mmio_periph #(
    .DEB_CYCLES (4),
    .TICK_DIV   (3)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_addr   (addr),
    .i_wen    (wen),
    .i_wdata  (wdata),
    .o_rdata  (rdata),
    .o_hit    (hit),
    .i_button (button),
    .o_led    (led)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    step(1);
    wen   = 1'b0;
    wdata = 16'h0000;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic hit_chk(input string tag, input logic [15:0] a, input logic exp);
    addr = a;
    #1;
    check(tag, {15'b0, hit}, {15'b0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    addr   = 16'h0000;
    wen    = 1'b0;
    wdata  = 16'h0000;
    button = 1'b0;

    // Reset
    step(3);
    rst_n = 1'b1;
    check("rst_led", {10'b0, led}, 16'h0000);
    read_chk("rst_btn", 16'h007C, 16'h0000);
    read_chk("rst_tick", 16'h0078, 16'h0000);
    hit_chk("unmapped_hit", 16'h0000, 1'b0);
    read_chk("unmapped_rdata", 16'h0000, 16'h0000);

    // Tick: one increment every 3 clocks
    step(8);
    read_chk("tick_8clk", 16'h0078, 16'h0002);
    step(1);
    read_chk("tick_9clk", 16'h0078, 16'h0003);
    hit_chk("tick_hit", 16'h0078, 1'b1);
    hit_chk("odd_79_hit", 16'h0079, 1'b0);
    store(16'h0078, 16'hFFFF);
    read_chk("tick_store", 16'h0078, 16'hFFFF);
    step(1);
    read_chk("tick_hold", 16'h0078, 16'hFFFF);
    step(1);
    read_chk("tick_wrap", 16'h0078, 16'h0000);
    step(2);
    store(16'h0078, 16'h1234);  // lands on an increment edge
    read_chk("tick_store_wins", 16'h0078, 16'h1234);
    step(2);
    read_chk("tick_phase_kept", 16'h0078, 16'h1234);
    step(1);
    read_chk("tick_after_store", 16'h0078, 16'h1235);

    // LED
    store(16'h007A, 16'hFFEA);
    check("led_out", {10'b0, led}, 16'h002A);
    read_chk("led_read", 16'h007A, 16'h002A);
    hit_chk("led_hit", 16'h007A, 1'b1);
    store(16'h007B, 16'h0015);
    check("led_unmapped_store", {10'b0, led}, 16'h002A);
    hit_chk("odd_7b_hit", 16'h007B, 1'b0);
    read_chk("odd_7b_rdata", 16'h007B, 16'h0000);

    // Debounce: 3-clock glitch is rejected
    button = 1'b1;
    step(3);
    button = 1'b0;
    step(6);
    read_chk("glitch_rejected", 16'h007C, 16'h0000);

    // Debounce: stable press takes exactly 6 clocks
    button = 1'b1;
    step(5);
    read_chk("press_5clk", 16'h007C, 16'h0000);
    step(1);
    read_chk("press_6clk", 16'h007C, 16'h0003);

    // W1C
    store(16'h007C, 16'h0001);
    read_chk("w1c_bit0_only", 16'h007C, 16'h0003);
    store(16'h007C, 16'h0002);
    read_chk("w1c_clear", 16'h007C, 16'h0001);
    button = 1'b0;
    step(6);
    read_chk("release", 16'h007C, 16'h0000);

    // Rise and clear on the same edge: set wins
    button = 1'b1;
    step(5);
    store(16'h007C, 16'h0002);
    read_chk("set_wins", 16'h007C, 16'h0003);

    // Reset mid-debounce discards progress
    button = 1'b0;
    step(6);
    read_chk("release2", 16'h007C, 16'h0002);
    button = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    read_chk("midrst_btn", 16'h007C, 16'h0000);
    check("midrst_led", {10'b0, led}, 16'h0000);
    step(5);
    read_chk("midrst_5clk", 16'h007C, 16'h0000);
    step(1);
    read_chk("midrst_6clk", 16'h007C, 16'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
